// File: rtl/dlx_ex_operand_stage.sv
// dlx_ex_operand_stage
//   ID/EX pipeline register and operand-bypass stage in front of the ALU.
//   Each cycle it captures the decoded instruction. It resolves read-after-write
//   dependences by forwarding from EX (alu_out), MEM and WB, in that priority.
//   On a load-use dependence it inserts a one-cycle bubble.
//   It also counts inserted bubbles with a saturating counter.
//
// Ports
//   CLK, RESET_N          clock (rising edge), asynchronous active-low reset
//   id_*                  decoded instruction from the decode slot
//   alu_out               result of the instruction currently in EX
//   mem_wr_en/rd/data     MEM-stage writer
//   wb_wr_en/rd/data      WB-stage writer
//   ex_hold               back-end stall, freezes this stage
//   flush                 squashes the decode slot and the EX slot
//   RSbus/RTbus/Imm/UseImm/SEL  registered ALU operands and select
//   ex_valid/ex_rd_addr/ex_wr_en/ex_is_load  registered EX-slot control
//   id_stall              combinational: decode must hold its instruction
//   bubble_cnt            number of load-use bubbles, saturating at all-ones
module dlx_ex_operand_stage #(
   parameter int DW   = 32,
   parameter int SELW = 8,
   parameter int CNTW = 16
) (
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic            id_valid,
   input  logic [4:0]      id_rs_addr,
   input  logic [4:0]      id_rt_addr,
   input  logic [DW-1:0]   id_rs_data,
   input  logic [DW-1:0]   id_rt_data,
   input  logic [DW-1:0]   id_imm,
   input  logic            id_use_imm,
   input  logic            id_uses_rt,
   input  logic [SELW-1:0] id_sel,
   input  logic [4:0]      id_rd_addr,
   input  logic            id_wr_en,
   input  logic            id_is_load,
   input  logic [DW-1:0]   alu_out,
   input  logic            mem_wr_en,
   input  logic [4:0]      mem_rd_addr,
   input  logic [DW-1:0]   mem_data,
   input  logic            wb_wr_en,
   input  logic [4:0]      wb_rd_addr,
   input  logic [DW-1:0]   wb_data,
   input  logic            ex_hold,
   input  logic            flush,
   output logic [DW-1:0]   RSbus,
   output logic [DW-1:0]   RTbus,
   output logic [DW-1:0]   Imm,
   output logic            UseImm,
   output logic [SELW-1:0] SEL,
   output logic            ex_valid,
   output logic [4:0]      ex_rd_addr,
   output logic            ex_wr_en,
   output logic            ex_is_load,
   output logic            id_stall,
   output logic [CNTW-1:0] bubble_cnt
);

   logic [DW-1:0]   rs_p1, rt_p1, imm_p1;
   logic            use_imm_p1;
   logic [SELW-1:0] sel_p1;
   logic            vld_p1, wr_en_p1, is_load_p1;
   logic [4:0]      rd_p1;
   logic [CNTW-1:0] cnt_p1;

   logic [DW-1:0]   rs_fwd, rt_fwd;
   logic            lu;

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
      return (c == {CNTW{1'b1}}) ? c : c + 1'b1;
   endfunction

   // Forwarding: newest producer wins. A load in EX has no data yet, so it
   // never matches here; the load-use bubble covers that case.
   function automatic logic [DW-1:0] bypass(input logic [4:0]    src,
                                            input logic [DW-1:0] rf_val,
                                            input logic          ex_hit_en,
                                            input logic [4:0]    ex_rd,
                                            input logic [DW-1:0] ex_val,
                                            input logic          m_en,
                                            input logic [4:0]    m_rd,
                                            input logic [DW-1:0] m_val,
                                            input logic          w_en,
                                            input logic [4:0]    w_rd,
                                            input logic [DW-1:0] w_val);
      if (src == 5'd0)                        return '0;
      else if (ex_hit_en && ex_rd == src)     return ex_val;
      else if (m_en && m_rd == src)           return m_val;
      else if (w_en && w_rd == src)           return w_val;
      else                                    return rf_val;
   endfunction

   // p0: decode-side operand resolution and hazard detection
   always_comb begin
      rs_fwd = bypass(id_rs_addr, id_rs_data, vld_p1 & wr_en_p1 & ~is_load_p1,
                      rd_p1, alu_out, mem_wr_en, mem_rd_addr, mem_data,
                      wb_wr_en, wb_rd_addr, wb_data);
      rt_fwd = bypass(id_rt_addr, id_rt_data, vld_p1 & wr_en_p1 & ~is_load_p1,
                      rd_p1, alu_out, mem_wr_en, mem_rd_addr, mem_data,
                      wb_wr_en, wb_rd_addr, wb_data);
      lu = vld_p1 & is_load_p1 & wr_en_p1 & (rd_p1 != 5'd0) & id_valid &
           ((id_rs_addr == rd_p1) | (id_uses_rt & (id_rt_addr == rd_p1)));
      // Gated by reset so decode never sees a stall while the stage is held in reset.
      id_stall = RESET_N & (ex_hold | lu) & ~flush;
   end

   // p1: EX-slot registers driving the ALU
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rs_p1      <= '0;
         rt_p1      <= '0;
         imm_p1     <= '0;
         use_imm_p1 <= 1'b0;
         sel_p1     <= '0;
         vld_p1     <= 1'b0;
         rd_p1      <= '0;
         wr_en_p1   <= 1'b0;
         is_load_p1 <= 1'b0;
         cnt_p1     <= '0;
      end else if (flush) begin
         vld_p1     <= 1'b0;
         wr_en_p1   <= 1'b0;
         is_load_p1 <= 1'b0;
      end else if (ex_hold) begin
         vld_p1     <= vld_p1;
      end else if (lu) begin
         vld_p1     <= 1'b0;
         wr_en_p1   <= 1'b0;
         is_load_p1 <= 1'b0;
         sel_p1     <= '0;
         cnt_p1     <= sat_inc(cnt_p1);
      end else begin
         rs_p1      <= rs_fwd;
         rt_p1      <= rt_fwd;
         imm_p1     <= id_imm;
         use_imm_p1 <= id_use_imm;
         sel_p1     <= id_sel;
         rd_p1      <= id_rd_addr;
         is_load_p1 <= id_is_load;
         vld_p1     <= id_valid;
         wr_en_p1   <= id_valid & id_wr_en;
      end
   end

   assign RSbus      = rs_p1;
   assign RTbus      = rt_p1;
   assign Imm        = imm_p1;
   assign UseImm     = use_imm_p1;
   assign SEL        = sel_p1;
   assign ex_valid   = vld_p1;
   assign ex_rd_addr = rd_p1;
   assign ex_wr_en   = wr_en_p1;
   assign ex_is_load = is_load_p1;
   assign bubble_cnt = cnt_p1;

endmodule

// File: tb/tb_dlx_ex_operand_stage.sv
module tb_dlx_ex_operand_stage;

   localparam int DW = 32, SELW = 8, CNTW = 4;

   logic            CLK = 1'b0;
   logic            RESET_N;
   logic            id_valid, id_use_imm, id_uses_rt, id_wr_en, id_is_load;
   logic [4:0]      id_rs_addr, id_rt_addr, id_rd_addr;
   logic [DW-1:0]   id_rs_data, id_rt_data, id_imm;
   logic [SELW-1:0] id_sel;
   logic [DW-1:0]   alu_out, mem_data, wb_data;
   logic            mem_wr_en, wb_wr_en, ex_hold, flush;
   logic [4:0]      mem_rd_addr, wb_rd_addr;
   logic [DW-1:0]   RSbus, RTbus, Imm;
   logic            UseImm, ex_valid, ex_wr_en, ex_is_load, id_stall;
   logic [SELW-1:0] SEL;
   logic [4:0]      ex_rd_addr;
   logic [CNTW-1:0] bubble_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model of the EX slot
   logic [DW-1:0]   m_rs, m_rt, m_imm;
   logic            m_useimm, m_valid, m_wr, m_ld;
   logic [SELW-1:0] m_sel;
   logic [4:0]      m_rd;
   int              m_cnt;

   dlx_ex_operand_stage #(.DW(DW), .SELW(SELW), .CNTW(CNTW)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_use_imm(id_use_imm), .id_uses_rt(id_uses_rt), .id_sel(id_sel),
      .id_rd_addr(id_rd_addr), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
      .alu_out(alu_out), .mem_wr_en(mem_wr_en), .mem_rd_addr(mem_rd_addr),
      .mem_data(mem_data), .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr),
      .wb_data(wb_data), .ex_hold(ex_hold), .flush(flush),
      .RSbus(RSbus), .RTbus(RTbus), .Imm(Imm), .UseImm(UseImm), .SEL(SEL),
      .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr), .ex_wr_en(ex_wr_en),
      .ex_is_load(ex_is_load), .id_stall(id_stall), .bubble_cnt(bubble_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_rs = '0; m_rt = '0; m_imm = '0; m_useimm = 1'b0; m_sel = '0;
      m_valid = 1'b0; m_wr = 1'b0; m_ld = 1'b0; m_rd = '0; m_cnt = 0;
   endtask

   // Value of register src as the instruction in decode should see it:
   // search producers from youngest (EX) to oldest (WB), else register file.
   function automatic logic [DW-1:0] m_fwd(input logic [4:0] src, input logic [DW-1:0] rf);
      logic          hit [3];
      logic [4:0]    a   [3];
      logic [DW-1:0] d   [3];
      hit[0] = m_valid && m_wr && !m_ld; a[0] = m_rd;        d[0] = alu_out;
      hit[1] = mem_wr_en;                a[1] = mem_rd_addr; d[1] = mem_data;
      hit[2] = wb_wr_en;                 a[2] = wb_rd_addr;  d[2] = wb_data;
      if (src == 5'd0) return '0;
      for (int i = 0; i < 3; i++)
         if (hit[i] && a[i] == src) return d[i];
      return rf;
   endfunction

   function automatic logic m_lu();
      return m_valid && m_ld && m_wr && m_rd != 5'd0 && id_valid &&
             (id_rs_addr == m_rd || (id_uses_rt && id_rt_addr == m_rd));
   endfunction

   task automatic m_edge();
      logic [DW-1:0] nrs, nrt;
      nrs = m_fwd(id_rs_addr, id_rs_data);
      nrt = m_fwd(id_rt_addr, id_rt_data);
      if (flush) begin
         m_valid = 1'b0; m_wr = 1'b0; m_ld = 1'b0;
      end else if (ex_hold) begin
         m_valid = m_valid;
      end else if (m_lu()) begin
         m_valid = 1'b0; m_wr = 1'b0; m_ld = 1'b0; m_sel = '0;
         if (m_cnt < (1 << CNTW) - 1) m_cnt = m_cnt + 1;
      end else begin
         m_rs = nrs; m_rt = nrt; m_imm = id_imm; m_useimm = id_use_imm;
         m_sel = id_sel; m_rd = id_rd_addr; m_ld = id_is_load;
         m_valid = id_valid; m_wr = id_valid && id_wr_en;
      end
   endtask

   // Called just after a rising edge: checks id_stall, clocks once, updates model.
   task automatic tick();
      #1;
      chk("id_stall", {63'd0, id_stall}, {63'd0, ex_hold || m_lu()} & {63'd0, !flush});
      @(posedge CLK);
      m_edge();
      #1;
   endtask

   task automatic check_all();
      chk("ex_valid",   {63'd0, ex_valid},   {63'd0, m_valid});
      chk("ex_wr_en",   {63'd0, ex_wr_en},   {63'd0, m_wr});
      chk("ex_is_load", {63'd0, ex_is_load}, {63'd0, m_ld});
      chk("bubble_cnt", {60'd0, bubble_cnt}, 64'(m_cnt));
      if (m_valid) begin
         chk("RSbus",      {32'd0, RSbus},      {32'd0, m_rs});
         chk("RTbus",      {32'd0, RTbus},      {32'd0, m_rt});
         chk("Imm",        {32'd0, Imm},        {32'd0, m_imm});
         chk("UseImm",     {63'd0, UseImm},     {63'd0, m_useimm});
         chk("SEL",        {56'd0, SEL},        {56'd0, m_sel});
         chk("ex_rd_addr", {59'd0, ex_rd_addr}, {59'd0, m_rd});
      end
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic wr, input logic ld,
                         input logic usert, input logic [DW-1:0] rsd,
                         input logic [DW-1:0] rtd, input logic [SELW-1:0] sel);
      id_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
      id_wr_en = wr; id_is_load = ld; id_uses_rt = usert;
      id_rs_data = rsd; id_rt_data = rtd; id_sel = sel;
      id_imm = 32'h0000_0042; id_use_imm = 1'b0;
   endtask

   task automatic clr_back();
      alu_out = '0; mem_wr_en = 1'b0; mem_rd_addr = '0; mem_data = '0;
      wb_wr_en = 1'b0; wb_rd_addr = '0; wb_data = '0; ex_hold = 1'b0; flush = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_RSbus"},  {32'd0, RSbus}, 64'd0);
      chk({tag, "_RTbus"},  {32'd0, RTbus}, 64'd0);
      chk({tag, "_Imm"},    {32'd0, Imm},   64'd0);
      chk({tag, "_ctrl"},   {56'd0, UseImm, ex_valid, ex_wr_en, ex_is_load, id_stall, 3'd0}, 64'd0);
      chk({tag, "_SEL"},    {56'd0, SEL},   64'd0);
      chk({tag, "_rd"},     {59'd0, ex_rd_addr}, 64'd0);
      chk({tag, "_cnt"},    {60'd0, bubble_cnt}, 64'd0);
   endtask

   initial begin
      logic [SELW-1:0] sel_hold;
      RESET_N = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      clr_back();
      ex_hold = 1'b1;
      m_reset();
      #12;
      chk_reset_outputs("reset");
      ex_hold = 1'b0;
      RESET_N = 1'b1;
      @(posedge CLK); #1;

      // EX forwarding beats MEM
      set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 32'h5, 32'h6, 8'h01);
      tick(); check_all();
      alu_out = 32'h10; mem_wr_en = 1'b1; mem_rd_addr = 5'd3; mem_data = 32'h20;
      set_id(1'b1, 5'd3, 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 32'h99, 32'h98, 8'h02);
      tick(); check_all();
      chk("ex_fwd_RSbus", {32'd0, RSbus}, 64'h10);

      // MEM beats WB; r0 never forwarded
      clr_back();
      mem_wr_en = 1'b1; mem_rd_addr = 5'd5; mem_data = 32'hA;
      wb_wr_en = 1'b1; wb_rd_addr = 5'd5; wb_data = 32'hB;
      set_id(1'b1, 5'd1, 5'd5, 5'd8, 1'b1, 1'b0, 1'b1, 32'h1, 32'h77, 8'h03);
      tick(); check_all();
      chk("mem_over_wb_RTbus", {32'd0, RTbus}, 64'hA);
      clr_back();
      wb_wr_en = 1'b1; wb_rd_addr = 5'd0; wb_data = 32'hFF;
      set_id(1'b1, 5'd0, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 32'h77, 32'h1, 8'h04);
      tick(); check_all();
      chk("r0_RSbus", {32'd0, RSbus}, 64'h0);

      // Load-use bubble then MEM forward
      clr_back();
      set_id(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, '0, '0, 8'h05);
      tick(); check_all();
      set_id(1'b1, 5'd4, 5'd1, 5'd6, 1'b1, 1'b0, 1'b1, 32'h55, 32'h1, 8'h06);
      #1 chk("lu_stall", {63'd0, id_stall}, 64'd1);
      tick(); check_all();
      chk("lu_bubble_valid", {63'd0, ex_valid}, 64'd0);
      chk("lu_bubble_cnt", {60'd0, bubble_cnt}, 64'd1);
      mem_wr_en = 1'b1; mem_rd_addr = 5'd4; mem_data = 32'h1234;
      #1 chk("lu_release_stall", {63'd0, id_stall}, 64'd0);
      tick(); check_all();
      chk("lu_mem_fwd_RSbus", {32'd0, RSbus}, 64'h1234);

      // Hold for three cycles while decode inputs change
      clr_back();
      sel_hold = SEL;
      ex_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_id(1'b1, 5'd2, 5'd3, 5'd10, 1'b1, 1'b0, 1'b1, $urandom, $urandom, 8'hE0 + 8'(i));
         tick(); check_all();
         chk("hold_RSbus", {32'd0, RSbus}, 64'h1234);
         chk("hold_SEL", {56'd0, SEL}, {56'd0, sel_hold});
      end
      flush = 1'b1;
      #1 chk("flush_hold_stall", {63'd0, id_stall}, 64'd0);
      tick(); check_all();
      chk("flush_valid", {63'd0, ex_valid}, 64'd0);

      // Reset asserted mid-cycle with a valid EX slot
      clr_back();
      set_id(1'b1, 5'd2, 5'd3, 5'd11, 1'b1, 1'b1, 1'b1, 32'h3, 32'h4, 8'h07);
      tick(); check_all();
      ex_hold = 1'b1;
      #3 RESET_N = 1'b0;
      #1 m_reset();
      chk_reset_outputs("midreset");
      #2 RESET_N = 1'b1;
      clr_back();
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick(); check_all();

      // Saturation of the bubble counter
      for (int i = 0; i < 17; i++) begin
         set_id(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, '0, '0, 8'h08);
         tick();
         set_id(1'b1, 5'd1, 5'd4, 5'd6, 1'b1, 1'b0, 1'b1, '0, '0, 8'h09);
         tick();
      end
      check_all();
      chk("sat_cnt", {60'd0, bubble_cnt}, 64'hF);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 1) == 1, $urandom, $urandom, 8'($urandom));
         id_imm = $urandom; id_use_imm = $urandom_range(0, 1) == 1;
         alu_out = $urandom;
         mem_wr_en = $urandom_range(0, 1) == 1; mem_rd_addr = 5'($urandom_range(0, 7)); mem_data = $urandom;
         wb_wr_en = $urandom_range(0, 1) == 1; wb_rd_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
         ex_hold = $urandom_range(0, 7) == 0;
         flush = $urandom_range(0, 9) == 0;
         tick(); check_all();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
